// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Sequencing controller for the 5-stage LEGv8 pipeline. It drives the load
// enables and synchronous bubble-clears of the PC and the IF/ID, ID/EX,
// EX/MEM and MEM/WB registers. It handles:
//   - load-use stalls,
//   - taken-branch flushes,
//   - data-memory wait states, with a watchdog trap on a stuck access.
// Optional feature macro: PIPE_HAZARD_CTRL_STATS_EN. When it is defined, the
// stall and flush statistics counters are built. When it is undefined, both
// counter outputs are tied to zero.

module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rn,
  input  logic [4:0]       ifid_rm,
  input  logic             mem_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             fault,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    TRAP  = 2'd2
  } state_t;

  localparam logic [4:0]       XZR       = 5'd31;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] wcnt_q;
  logic [CNT_W-1:0] wcnt_d;
  logic [CNT_W-1:0] wcnt_inc;

  logic frozen;
  logic hazard_regs;
  logic branch_go;
  logic load_use_go;
  logic timeout_hit;

  // Classify the current cycle.
  // Priority order: freeze, then branch, then load-use, then normal.
  // The TRAP state suppresses every class.
  always_comb begin
    frozen      = 1'b0;
    hazard_regs = 1'b0;
    branch_go   = 1'b0;
    load_use_go = 1'b0;
    wcnt_inc    = wcnt_q + CNT_ONE;
    timeout_hit = 1'b0;

    // X31 reads as zero, so a load targeting it can never feed a consumer.
    hazard_regs = idex_memread && (idex_rd != XZR) &&
                  ((idex_rd == ifid_rn) || (idex_rd == ifid_rm));

    unique case (state_q)
      RUN:     frozen = dmem_req && !dmem_ready;
      MWAIT:   frozen = !dmem_ready;
      default: frozen = 1'b0;
    endcase

    if (state_q != TRAP) begin
      branch_go   = !frozen && mem_branch_taken;
      load_use_go = !frozen && !mem_branch_taken && hazard_regs;
    end

    timeout_hit = frozen && (wcnt_inc == TIMEOUT_C);
  end

  // Compute the next FSM state and the wait-counter update.
  // wcnt counts the current run of consecutive frozen cycles. It clears on
  // the first cycle that is not frozen.
  always_comb begin
    state_d = state_q;
    wcnt_d  = '0;

    unique case (state_q)
      RUN, MWAIT: begin
        if (frozen) begin
          wcnt_d = wcnt_inc;
          if (timeout_hit) begin
            state_d = TRAP;
          end else begin
            state_d = MWAIT;
          end
        end else if (dmem_ready) begin
          state_d = RUN;
        end
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State register and wait-counter register.
  // Both return to idle immediately on an asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Drive the pipeline-register controls combinationally from state and inputs.
  // While reset is held, everything is quiet.
  // A freeze holds every register and clears none of them. Any branch or
  // hazard stays in the frozen registers and is handled once memory releases.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    fault       = 1'b0;

    if (reset) begin
      if (state_q == TRAP) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        fault       = 1'b1;
      end else if (frozen) begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end else if (branch_go) begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_use_go) begin
        // Hold PC and IF/ID so the consumer re-decodes next cycle.
        // Insert a bubble into ID/EX behind the load.
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        idex_flush = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end
    end
  end

`ifdef PIPE_HAZARD_CTRL_STATS_EN

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  // Saturating statistics.
  // A stall is any cycle outside TRAP in which the PC does not advance.
  // A flush is a taken-branch cycle.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q != TRAP) && (frozen || load_use_go) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (branch_go && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  // Statistics registers, cleared by reset only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

`else

  assign stall_cnt = '0;
  assign flush_cnt = '0;

`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage LEGv8 datapath. Drives the enable and synchronous-clear controls of the PC register and the four `flopr`-based pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves load-use stalls, taken-branch flushes and data-memory wait states. A watchdog traps on a stuck memory access.

## Interface
Parameters:
- `TIMEOUT`, 255: consecutive frozen memory-wait cycles before trapping; legal range 1..2^`CNT_W`-1.
- `CNT_W`, 16: width of the wait and statistics counters.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `idex_memread` in 1: instruction in ID/EX is a load (LDUR).
- `idex_rd` in 5: destination register of the ID/EX instruction.
- `ifid_rn`, `ifid_rm` in 5: source registers of the IF/ID instruction.
- `mem_branch_taken` in 1: PCSrc resolved in the MEM stage.
- `dmem_req` in 1: EX/MEM instruction accesses data memory.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1: register load enables.
- `ifid_flush`, `idex_flush`, `exmem_flush` out 1: synchronous clear to bubble.
- `fault` out 1: sticky memory-timeout trap.
- `stall_cnt`, `flush_cnt` out `CNT_W`: statistics counters (see Configuration).

## Operation
- FSM states:
  - RUN: normal operation.
  - MWAIT: memory freeze in progress.
  - TRAP: terminal until reset.
- Outputs are combinational from the current state and inputs. Cycle priority is freeze > branch > load-use > normal.
- Freeze condition: (RUN and `dmem_req`=1 and `dmem_ready`=0) or (MWAIT and `dmem_ready`=0).
  - All five enables are 0; all flushes are 0.
- Branch: `mem_branch_taken`=1, not frozen, state RUN or MWAIT.
  - All enables are 1; `ifid_flush`=`idex_flush`=`exmem_flush`=1 for that cycle.
- Load-use: `idex_memread`=1, `idex_rd`≠31, and (`idex_rd`=`ifid_rn` or `idex_rd`=`ifid_rm`), with no freeze and no branch.
  - `pc_en`=`ifid_en`=0; `idex_flush`=1; `idex_en`=`exmem_en`=`memwb_en`=1.
- Register X31 (XZR) never creates a hazard.
- Normal cycle: all enables 1, all flushes 0.
- TRAP: all enables 0, all flushes 1, `fault`=1. Inputs are ignored.
- Wait counter `wcnt` (internal, `CNT_W` bits):
  - Increments every frozen cycle.
  - Clears on any non-frozen cycle.
- Transitions at the rising edge:
  - RUN→MWAIT when frozen and `wcnt`+1 < `TIMEOUT`.
  - RUN or MWAIT→TRAP when frozen and `wcnt`+1 = `TIMEOUT`.
  - MWAIT→RUN when `dmem_ready`=1.
  - TRAP holds.
- A branch or load-use occurring during a freeze is deferred, not lost. The frozen registers re-present it on the first unfrozen cycle.

## Timing
- Reset (`reset`=0, asynchronous):
  - State is RUN; `wcnt`, `stall_cnt`, `flush_cnt` and `fault` are 0.
  - While reset is asserted, all enables are 0 and all flushes are 0.
  - Reset may be asserted in any state, including mid-freeze or TRAP, and returns to RUN immediately.
- Control outputs have zero-cycle latency from inputs; there is no registered delay.
- A load-use stall lasts exactly 1 cycle per hazard.
- A branch flush lasts exactly 1 cycle.
- A freeze lasts until the cycle `dmem_ready`=1; that cycle is unfrozen.
- `fault` rises one edge after the `TIMEOUT`-th consecutive frozen cycle.

## Configuration
- Macro: `PIPE_HAZARD_CTRL_STATS_EN`.
- Defined:
  - `stall_cnt` increments on every cycle with `pc_en`=0 outside TRAP.
  - `flush_cnt` increments on every branch-flush cycle.
  - Both saturate at 2^`CNT_W`-1 and reset to 0.
- Undefined: no counter flops are compiled in; `stall_cnt` and `flush_cnt` are tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- Load-use: `idex_memread`=1, `idex_rd`=5, `ifid_rn`=5 for 1 cycle.
  - That cycle: `pc_en`=0, `ifid_en`=0, `idex_flush`=1.
  - Next cycle, with the hazard cleared: all enables 1. `stall_cnt`=1 when stats are enabled.
- XZR: `idex_memread`=1, `idex_rd`=31, `ifid_rm`=31.
  - No stall; all enables 1, all flushes 0.
- Branch and load-use together: `mem_branch_taken`=1 plus a matching load-use.
  - Branch wins: all enables 1, three flushes 1. `flush_cnt`=1 and `stall_cnt`=0 when stats are enabled.
- Memory wait: `dmem_req`=1, `dmem_ready`=0 for 3 cycles, then 1.
  - Three cycles with all enables 0, then a cycle with enables 1.
  - State returns to RUN; `fault` stays 0.
- Timeout: `TIMEOUT`=4, `dmem_req`=1, `dmem_ready`=0 held.
  - After the 4th frozen edge: `fault`=1, all flushes 1.
  - Raising `dmem_ready` keeps the trap; asserting `reset`=0 mid-trap clears `fault` asynchronously.
- Mid-freeze branch: `mem_branch_taken`=1 and `dmem_ready`=0 for 2 cycles, then `dmem_ready`=1.
  - Flushes are 0 during the freeze.
  - Flushes are 1 on the release cycle.
